// File: rtl/any1_pkg.sv
// Shared ANY-1 address-generation types and constants.
// FIFO entries are sized for the widest supported id and tag.
package any1_pkg;

  localparam int AWID      = 32;
  localparam int AGEN_NREQ = 4;
  localparam int AGEN_IDW  = 3;
  localparam int AGEN_TAGW = 8;

  typedef struct packed {
    logic [AWID-1:0]      ea;
    logic [AGEN_IDW-1:0]  id;
    logic [AGEN_TAGW-1:0] tag;
  } agen_result_t;

  // Displacement is split across two instruction fields and sign-extended.
  function automatic logic [63:0] agen_disp(input logic [63:0] ir);
    return {{42{ir[63]}}, ir[63:50], ir[39:32]};
  endfunction

endpackage

// File: rtl/any1_agen.sv
// ANY-1 effective-address generator: (disp + ia + ib) << Sc, truncated to AWID.
// Purely combinational; overflow is deliberately unchecked.
module any1_agen
  import any1_pkg::*;
(
  input  logic [63:0]     i_ir,
  input  logic [63:0]     i_ia,
  input  logic [63:0]     i_ib,
  output logic [AWID-1:0] o_ea
);

  logic [63:0] w_sum;
  logic        w_unused_ir;

  assign w_sum       = agen_disp(i_ir) + i_ia + i_ib;
  assign o_ea        = AWID'(w_sum << i_ir[43:41]);
  assign w_unused_ir = ^{i_ir[49:44], i_ir[40], i_ir[31:0]};

endmodule

// File: rtl/any1_rr_arb.sv
// Round-robin arbiter; priority starts one past the last granted requester.
// Grant is combinational and gated by i_en; the pointer moves only on a real grant.
module any1_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx
);

  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_idx;
  logic           w_any;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    w_idx = r_last;
    w_any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[rr_idx(r_last, k)]) begin
        w_idx = rr_idx(r_last, k);
        w_any = 1'b1;
      end
    end
  end

  assign o_grant     = (i_en && w_any) ? (NREQ'(1) << w_idx) : '0;
  assign o_grant_idx = w_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= IDW'(NREQ - 1);
    end else if (i_en && w_any) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/any1_agen_sched.sv
// Shares one any1_agen among NREQ requesters; 2-cycle grant-to-out_valid latency.
// Credit-based issue keeps in-flight + buffered results <= 2; out_* hold while stalled.
module any1_agen_sched
  import any1_pkg::*;
#(
  parameter int NREQ = AGEN_NREQ,
  parameter int IDW  = $clog2(NREQ),
  parameter int TAGW = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ-1:0][63:0]     i_req_ir,
  input  logic [NREQ-1:0][63:0]     i_req_ia,
  input  logic [NREQ-1:0][63:0]     i_req_ib,
  input  logic [NREQ-1:0][TAGW-1:0] i_req_tag,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [AWID-1:0]           o_out_ea,
  output logic [IDW-1:0]            o_out_id,
  output logic [TAGW-1:0]           o_out_tag
);

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_fire;
  logic            w_pop;
  logic            w_push;
  logic            w_credit;
  logic            w_en;
  logic [2:0]      w_occ;
  logic [AWID-1:0] w_ea;
  agen_result_t    w_push_dat;
  agen_result_t    w_head;
  logic            w_unused_head;

  logic [63:0]     r_ir;
  logic [63:0]     r_ia;
  logic [63:0]     r_ib;
  logic            r_s1_vld;
  logic [IDW-1:0]  r_s1_id;
  logic [TAGW-1:0] r_s1_tag;
  agen_result_t    r_mem [2];
  logic            r_wp;
  logic            r_rp;
  logic [1:0]      r_cnt;

  // A pop this cycle frees a slot, so issue can resume the same cycle out_ready returns.
  assign w_pop    = o_out_valid & i_out_ready;
  assign w_occ    = {1'b0, r_cnt} + {2'b0, r_s1_vld} - {2'b0, w_pop};
  assign w_credit = (w_occ < 3'd2);
  assign w_en     = !i_flush && !i_rst && w_credit;

  any1_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_en),
    .i_req       (i_req_valid),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx)
  );

  assign o_req_ready = w_grant;
  assign w_fire      = |w_grant;

  // Operand registers hold the last winner's values when nothing is granted.
  always_ff @(posedge i_clk) begin
    if (w_fire) begin
      r_ir     <= i_req_ir[w_idx];
      r_ia     <= i_req_ia[w_idx];
      r_ib     <= i_req_ib[w_idx];
      r_s1_id  <= w_idx;
      r_s1_tag <= i_req_tag[w_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_fire;
    end
  end

  any1_agen u_agen (
    .i_ir (r_ir),
    .i_ia (r_ia),
    .i_ib (r_ib),
    .o_ea (w_ea)
  );

  assign w_push         = r_s1_vld & !i_flush;
  assign w_push_dat.ea  = w_ea;
  assign w_push_dat.id  = AGEN_IDW'(r_s1_id);
  assign w_push_dat.tag = AGEN_TAGW'(r_s1_tag);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_cnt <= 2'd0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wp] <= w_push_dat;
    end
  end

  // Payload is forced to zero when empty so reset/flush leave clean outputs.
  assign w_head        = r_mem[r_rp];
  assign o_out_valid   = (r_cnt != 2'd0);
  assign o_out_ea      = o_out_valid ? w_head.ea : '0;
  assign o_out_id      = o_out_valid ? IDW'(w_head.id) : '0;
  assign o_out_tag     = o_out_valid ? TAGW'(w_head.tag) : '0;
  assign w_unused_head = ^w_head;

endmodule
